// File: rtl/op_fifo_if.sv
// rtl/op_fifo_if.sv - op_fifo handshake bundle; OP_FIFO_ERR_FLAGS_EN adds overflow/underflow
interface op_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wen;
  logic                  ren;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
`ifdef OP_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wen, ren, wdata,
    input  rdata, full, empty, count, overflow, underflow
  );
  modport slave (
    input  wen, ren, wdata,
    output rdata, full, empty, count, overflow, underflow
  );
`else
  modport master (
    output wen, ren, wdata,
    input  rdata, full, empty, count
  );
  modport slave (
    input  wen, ren, wdata,
    output rdata, full, empty, count
  );
`endif
endinterface

// File: rtl/op_fifo.sv
// rtl/op_fifo.sv - single-clock operand FIFO with registered read; OP_FIFO_ERR_FLAGS_EN adds sticky error flags
module op_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic    clock,
  input logic    reset,
  op_fifo_if.slave bus
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status is decoded from the registered count only, so wen/ren never reach the outputs.
  assign full_w  = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wen & ~full_w;
  assign rd_acc  = bus.ren & ~empty_w;

  // Storage array; deliberately not reset so contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; the read port latches the head on an accepted read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rdata_q <= mem[rd_ptr];
      end
    end
  end

  // Occupancy tracks the net effect of the accepted transfers this cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.full  = full_w;
  assign bus.empty = empty_w;
  assign bus.count = count_q;

`ifdef OP_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky flags recording any rejected request; only reset clears them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wen & full_w) begin
        overflow_q <= 1'b1;
      end
      if (bus.ren & empty_w) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_op_fifo.sv
// tb/tb_op_fifo.sv - scoreboard bench for op_fifo; honours OP_FIFO_ERR_FLAGS_EN
module tb_op_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  op_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  op_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO contents as a queue, plus expected read results.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_rdata = '0;
  logic          m_ovf   = 1'b0;
  logic          m_unf   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edge the DUT sees, from the pre-edge occupancy.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      exp_q.delete();
      m_rdata = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      bit wa;
      bit ra;
      wa = bus.wen && (mq.size() < DEPTH);
      ra = bus.ren && (mq.size() != 0);
      if (bus.wen && mq.size() == DEPTH) m_ovf = 1'b1;
      if (bus.ren && mq.size() == 0)     m_unf = 1'b1;
      if (ra) begin
        m_rdata = mq.pop_front();
        exp_q.push_back(m_rdata);
      end
      if (wa) mq.push_back(bus.wdata);
    end
  end

  // Monitor: compares DUT state against the model away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      check("count", int'(bus.count), mq.size());
      check("full",  int'(bus.full),  int'(mq.size() == DEPTH));
      check("empty", int'(bus.empty), int'(mq.size() == 0));
      if (exp_q.size() > 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("rdata_pop", int'(bus.rdata), int'(e));
      end else begin
        check("rdata_hold", int'(bus.rdata), int'(m_rdata));
      end
`ifdef OP_FIFO_ERR_FLAGS_EN
      check("overflow",  int'(bus.overflow),  int'(m_ovf));
      check("underflow", int'(bus.underflow), int'(m_unf));
`endif
    end
  end

  task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
    @(negedge clock);
    bus.wen   = w;
    bus.ren   = r;
    bus.wdata = d;
  endtask

  task automatic idle_check(input string name, input int cnt, input int rd);
    drive(1'b0, 1'b0, '0);
    #1;
    check({name, "_count"}, int'(bus.count), cnt);
    check({name, "_rdata"}, int'(bus.rdata), rd);
  endtask

  initial begin
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_empty", int'(bus.empty), 1);
    check("rst_full",  int'(bus.full),  0);
    check("rst_count", int'(bus.count), 0);
    check("rst_rdata", int'(bus.rdata), 0);
    @(negedge clock);
    reset = 1'b1;

    // Basic ordering
    drive(1, 0, 8'h11); drive(1, 0, 8'h22); drive(1, 0, 8'h33);
    idle_check("wr3", 3, 0);
    repeat (3) drive(0, 1, 8'h00);
    idle_check("rd3", 0, 8'h33);
    check("rd3_empty", int'(bus.empty), 1);

    // Overfill: 0x09 and 0x0A are dropped
    for (int i = 1; i <= 10; i++) drive(1, 0, DW'(i));
    idle_check("fill", 8, 8'h33);
    check("fill_full", int'(bus.full), 1);
`ifdef OP_FIFO_ERR_FLAGS_EN
    check("fill_ovf", int'(bus.overflow), 1);
`endif
    repeat (8) drive(0, 1, 8'h00);
    idle_check("drain", 0, 8'h08);

    // Read while empty holds rdata
    repeat (3) drive(0, 1, 8'h00);
    idle_check("rd_empty", 0, 8'h08);
`ifdef OP_FIFO_ERR_FLAGS_EN
    check("rd_empty_unf", int'(bus.underflow), 1);
`endif

    // Steady-state streaming across a pointer wrap
    for (int i = 0; i < 4; i++) drive(1, 0, DW'(8'h40 + i));
    for (int i = 0; i < 12; i++) drive(1, 1, DW'(8'h50 + i));
    idle_check("stream", 4, 8'h57);
    repeat (4) drive(0, 1, 8'h00);
    idle_check("stream_drain", 0, 8'h5B);

    // Simultaneous on empty: write only
    drive(1, 1, 8'h5A);
    idle_check("both_empty", 1, 8'h5B);
    drive(0, 1, 8'h00);
    idle_check("both_empty_rd", 0, 8'h5A);

    // Simultaneous on full: read only, wdata dropped
    for (int i = 0; i < 8; i++) drive(1, 0, DW'(8'h60 + i));
    drive(1, 1, 8'hEE);
    idle_check("both_full", 7, 8'h60);
    repeat (7) drive(0, 1, 8'h00);
    idle_check("both_full_drain", 0, 8'h67);

    // Asynchronous reset mid-cycle
    drive(1, 0, 8'hA1); drive(1, 0, 8'hA2); drive(0, 1, 8'h00);
    drive(0, 0, 8'h00);
    #2 reset = 1'b0;
    #1;
    check("arst_empty", int'(bus.empty), 1);
    check("arst_full",  int'(bus.full),  0);
    check("arst_count", int'(bus.count), 0);
    check("arst_rdata", int'(bus.rdata), 0);
`ifdef OP_FIFO_ERR_FLAGS_EN
    check("arst_ovf", int'(bus.overflow),  0);
    check("arst_unf", int'(bus.underflow), 0);
`endif
    @(negedge clock);
    reset = 1'b1;
    drive(1, 0, 8'hC3);
    drive(0, 1, 8'h00);
    idle_check("post_rst", 0, 8'hC3);

    // Randomized traffic with varying write/read bias
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3;
      drive(($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5))),
            ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5))),
            DW'($urandom));
    end
    repeat (DEPTH + 1) drive(0, 1, 8'h00);
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);
    #1;
    check("final_empty", int'(bus.empty), 1);
    check("final_scoreboard", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
